// File: rtl/bitty_loader_pkg.sv
// Shared types and widths for the bitty UART instruction loader.
// UART_PARITY_EN adds the even-parity receiver state.
package bitty_loader_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: synchronizer, start/glitch check, data, stop.
// UART_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_rx_byte
  import bitty_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);

  rx_state_t         r_state;
  rx_state_t         w_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_rx_d;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_shift;
  logic              w_rx;
  logic              w_fall;
  logic              w_tick;
  logic              w_par_err;

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_d & ~r_sync2;
  assign w_tick = (r_state == S_START) ?
                  (r_cnt == HALF_M1) :
                  (r_cnt == FULL_M1);

  assign byte_data = r_shift;

`ifdef UART_PARITY_EN
  logic r_par_err;
  assign w_par_err = r_par_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (r_state == S_START) begin
      r_par_err <= 1'b0;
    end else if (r_state == S_PARITY && w_tick) begin
      r_par_err <= (^r_shift) ^ w_rx;
    end
  end
`else
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
      if (r_state == S_IDLE || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_START) begin
        r_bit <= '0;
      end
      if (r_state == S_DATA && w_tick) begin
        r_shift <= {w_rx, r_shift[BYTE_W-1:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) w_next = S_START;
      end
      S_START: begin
        if (w_tick) w_next = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick && r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_tick) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if (r_state == S_STOP && w_tick) begin
      byte_valid = w_rx & ~w_par_err;
      byte_err   = ~w_rx | w_par_err;
    end
  end

endmodule

// File: rtl/bitty_uart_loader.sv
// Pairs received UART bytes into 16-bit words and queues them for the core.
// UART_PARITY_EN (in uart_rx_byte) enables even-parity checking.
module bitty_uart_loader
  import bitty_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               frame_err,
  output logic               overflow,
  input  logic               clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BYTE_W-1:0]  w_byte;
  logic               w_byte_valid;
  logic               w_byte_err;
  logic [INSTR_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic               r_hi_phase;
  logic [BYTE_W-1:0]  r_hi_byte;
  logic               r_frame_err;
  logic               r_overflow;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (w_byte),
    .byte_valid (w_byte_valid),
    .byte_err   (w_byte_err)
  );

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = w_byte_valid & ~r_hi_phase;
  assign w_pop   = ~w_empty & instr_ready;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign instr_valid = ~w_empty;
  assign instr       = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= {r_hi_byte, w_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_phase <= 1'b1;
      r_hi_byte  <= '0;
    end else if (w_byte_err) begin
      r_hi_phase <= 1'b1;
    end else if (w_byte_valid) begin
      r_hi_phase <= ~r_hi_phase;
      if (r_hi_phase) r_hi_byte <= w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_byte_err)     r_frame_err <= 1'b1;
      else if (clear_err) r_frame_err <= 1'b0;
      if (w_drop)         r_overflow  <= 1'b1;
      else if (clear_err) r_overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitty_uart_loader.sv
// Directed self-checking bench for bitty_uart_loader at CLKS_PER_BIT=4.
// Build with UART_PARITY_EN to exercise the parity path as well.
module tb_bitty_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        frame_err;
  logic        overflow;
  logic        clear_err = 1'b0;

  int tests = 0;
  int fails = 0;
  int vcyc = 0;
  logic [15:0] popq [$];

  bitty_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_valid) vcyc++;
    if (instr_valid && instr_ready) popq.push_back(instr);
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cyc(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop_bit,
                           input logic par_bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
    drive_bit((^b) ^ par_bad);
`else
    if (par_bad) drive_bit(1'b1);
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(3);
    tests++;
    if (instr !== 16'h0) begin
      fails++;
      $display("FAIL reset_instr: got %h want 0000", instr);
    end
    tests++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", instr_valid);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ferr: got %b want 0", frame_err);
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b want 0", overflow);
    end
    rst = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_basic();
    popq.delete();
    vcyc = 0;
    instr_ready = 1'b1;
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    wait_cyc(10);
    tests++;
    if (popq.size() !== 1) begin
      fails++;
      $display("FAIL basic_count: got %0d want 1", popq.size());
    end
    tests++;
    if (popq.size() == 0 || popq[0] !== 16'h1234) begin
      fails++;
      $display("FAIL basic_word: got %h want 1234",
               popq.size() ? popq[0] : 16'hxxxx);
    end
    tests++;
    if (vcyc !== 1) begin
      fails++;
      $display("FAIL basic_vcyc: got %0d want 1", vcyc);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_ferr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] got;
    popq.delete();
    instr_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      send_byte(8'h00, 1'b1, 1'b0);
      send_byte(8'(w), 1'b1, 1'b0);
    end
    wait_cyc(10);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    tests++;
    if (instr !== 16'h0001) begin
      fails++;
      $display("FAIL ovf_hold: got %h want 0001", instr);
    end
    instr_ready = 1'b1;
    wait_cyc(10);
    tests++;
    if (popq.size() !== 4) begin
      fails++;
      $display("FAIL ovf_count: got %0d want 4", popq.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < popq.size()) ? popq[i] : 16'hxxxx;
      tests++;
      if (got !== 16'(i + 1)) begin
        fails++;
        $display("FAIL ovf_pop%0d: got %h want %h",
                 i, got, 16'(i + 1));
      end
    end
    tests++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_drain: got %b want 0", instr_valid);
    end
    clear_err = 1'b1;
    wait_cyc(1);
    clear_err = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_frame_err();
    popq.delete();
    instr_ready = 1'b1;
    send_byte(8'hAB, 1'b0, 1'b0);
    send_byte(8'hCD, 1'b1, 1'b0);
    send_byte(8'hEF, 1'b1, 1'b0);
    wait_cyc(10);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL ferr_flag: got %b want 1", frame_err);
    end
    tests++;
    if (popq.size() !== 1) begin
      fails++;
      $display("FAIL ferr_count: got %0d want 1", popq.size());
    end
    tests++;
    if (popq.size() == 0 || popq[0] !== 16'hCDEF) begin
      fails++;
      $display("FAIL ferr_word: got %h want cdef",
               popq.size() ? popq[0] : 16'hxxxx);
    end
    clear_err = 1'b1;
    wait_cyc(1);
    clear_err = 1'b0;
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL ferr_clear: got %b want 0", frame_err);
    end
  endtask

  task automatic test_glitch();
    popq.delete();
    instr_ready = 1'b1;
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(60);
    tests++;
    if (frame_err !== 1'b0 || popq.size() !== 0) begin
      fails++;
      $display("FAIL glitch_quiet: got ferr=%b n=%0d want 0 0",
               frame_err, popq.size());
    end
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    wait_cyc(10);
    tests++;
    if (popq.size() !== 1 || popq[0] !== 16'h1122) begin
      fails++;
      $display("FAIL glitch_word: got n=%0d %h want 1 1122",
               popq.size(), popq.size() ? popq[0] : 16'hxxxx);
    end
  endtask

  task automatic test_rst_midframe();
    logic [7:0] b;
    popq.delete();
    instr_ready = 1'b1;
    b = 8'h9A;
    send_byte(8'h11, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    tests++;
    if (instr_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state: got v=%b ferr=%b want 0 0",
               instr_valid, frame_err);
    end
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h78, 1'b1, 1'b0);
    wait_cyc(10);
    tests++;
    if (popq.size() !== 1 || popq[0] !== 16'h5678) begin
      fails++;
      $display("FAIL rstmid_word: got n=%0d %h want 1 5678",
               popq.size(), popq.size() ? popq[0] : 16'hxxxx);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    popq.delete();
    instr_ready = 1'b1;
    send_byte(8'h03, 1'b1, 1'b1);
    wait_cyc(4);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL par_bad: got %b want 1", frame_err);
    end
    clear_err = 1'b1;
    wait_cyc(1);
    clear_err = 1'b0;
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    wait_cyc(10);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL par_good_ferr: got %b want 0", frame_err);
    end
    tests++;
    if (popq.size() !== 1 || popq[0] !== 16'h0304) begin
      fails++;
      $display("FAIL par_word: got n=%0d %h want 1 0304",
               popq.size(), popq.size() ? popq[0] : 16'hxxxx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_rst_midframe();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
